mac_requant: RTL and testbench

- Output-side companion to the PE MAC: consumes the wide unsigned accumulator result (2*MAC_BW+4 bits, Q.2FRAC) and requantizes it to a MAC_BW-bit fractional word.
- Operations: rounding right shift by FRAC, then unsigned saturation.
- Two-stage valid/ready pipeline with a saturation-event counter; sits between the MAC array drain and the result writeback buffer.

---
 rtl/mac_requant.sv | 107 ++++++++++
 tb/tb_mac_requant.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_requant.sv
// Requantizes a wide unsigned MAC accumulator to BW bits: rounding shift by FRAC, then unsigned saturation.
// Latency 2 cycles; valid/ready with at most 2 words held, iReady drops only when both stages are full and oReady=0.
// Optional MAC_REQUANT_RNE_EN selects round-half-to-even; default is round-half-up.
`ifndef MAC_BW
`define MAC_BW 16
`endif

module mac_requant #(
    parameter int BW    = `MAC_BW,
    parameter int FRAC  = 15,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iValid,
    output logic                iReady,
    input  logic [2*BW+3:0]     iData,
    output logic                oValid,
    input  logic                oReady,
    output logic [BW-1:0]       oData,
    output logic                oSat,
    input  logic                iClr,
    output logic [CNT_W-1:0]    satCnt
);
    localparam int IW = 2*BW+4;
    localparam int SW = 2*BW+5;
    localparam logic [SW-1:0] ROUND = SW'(1) << (FRAC-1);

    logic          r_v1, r_v2;
    logic [SW-1:0] r_q;
    logic [BW-1:0] r_dat;
    logic          r_sat;
    logic [CNT_W-1:0] r_cnt;

    logic          w_adv2, w_acc, w_xfer;
    logic [SW-1:0] w_sum, w_q;
    logic          w_sat;
    logic [BW-1:0] w_dat;

    assign w_adv2 = r_v1 & (~r_v2 | oReady);
    assign iReady = ~r_v1 | w_adv2;
    assign w_acc  = iValid & iReady;
    assign w_xfer = r_v2 & oReady;

    assign w_sum = {1'b0, iData} + ROUND;

`ifdef MAC_REQUANT_RNE_EN
    localparam logic [IW-1:0] MASK = (IW'(1) << FRAC) - IW'(1);
    localparam logic [IW-1:0] HALF = IW'(1) << (FRAC-1);
    logic w_tie;
    // An exact tie with an even truncated value keeps the truncation instead of rounding up.
    assign w_tie = ((iData & MASK) == HALF) & ~iData[FRAC];
    assign w_q   = w_tie ? ({1'b0, iData} >> FRAC) : (w_sum >> FRAC);
`else
    assign w_q   = w_sum >> FRAC;
`endif

    assign w_sat = |r_q[SW-1:BW];
    assign w_dat = w_sat ? {BW{1'b1}} : r_q[BW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_q  <= '0;
        end else begin
            if (w_acc) begin
                r_v1 <= 1'b1;
                r_q  <= w_q;
            end else if (w_adv2) begin
                r_v1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2  <= 1'b0;
            r_dat <= '0;
            r_sat <= 1'b0;
        end else begin
            if (w_adv2) begin
                r_v2  <= 1'b1;
                r_dat <= w_dat;
                r_sat <= w_sat;
            end else if (oReady) begin
                r_v2  <= 1'b0;
            end
        end
    end

    // Clear takes priority over a same-cycle saturated transfer; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (iClr) begin
            r_cnt <= '0;
        end else if (w_xfer && r_sat && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign oValid = r_v2;
    assign oData  = r_dat;
    assign oSat   = r_sat;
    assign satCnt = r_cnt;

endmodule

// File: tb/tb_mac_requant.sv
// Scoreboard bench for mac_requant (BW=16, FRAC=15, CNT_W=2) with directed and random traffic.
module tb_mac_requant;
    localparam int BW    = 16;
    localparam int FRAC  = 15;
    localparam int CNT_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              iValid = 1'b0;
    logic              iReady;
    logic [2*BW+3:0]   iData = '0;
    logic              oValid;
    logic              oReady = 1'b1;
    logic [BW-1:0]     oData;
    logic              oSat;
    logic              iClr = 1'b0;
    logic [CNT_W-1:0]  satCnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic [16:0] sb[$];
    int m_cnt = 0;

    mac_requant #(.BW(BW), .FRAC(FRAC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .iValid(iValid), .iReady(iReady), .iData(iData),
        .oValid(oValid), .oReady(oReady), .oData(oData), .oSat(oSat),
        .iClr(iClr), .satCnt(satCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the requantization rules.
    function automatic logic [16:0] ref_q(input longint unsigned d);
        longint unsigned half, q;
        half = 64'd1 << (FRAC-1);
        q = (d + half) >> FRAC;
`ifdef MAC_REQUANT_RNE_EN
        if ((d % (2*half)) == half && ((d >> FRAC) % 2) == 0)
            q = d >> FRAC;
`endif
        if (q > 64'd65535) return {1'b1, 16'hFFFF};
        return {1'b0, q[15:0]};
    endfunction

    function automatic logic [35:0] gen();
        longint unsigned d;
        case ($urandom % 4)
            0: d = longint'($urandom_range(0, 1 << 20));
            1: d = (longint'($urandom % 65536) << 15) + 64'd16384 + longint'($urandom % 3) - 64'd1;
            2: d = (64'd65535 << 15) + longint'($urandom_range(0, 65536)) - 64'd16384;
            default: d = {28'd0, 4'($urandom), 32'($urandom)};
        endcase
        return 36'(d);
    endfunction

    // Monitor: inputs are stable at the falling edge, so accept/transfer are decided here.
    always @(negedge clk) begin
        logic [16:0] e;
        logic tsat;
        logic xfer;
        if (!rst_n) begin
            sb.delete();
            m_cnt = 0;
            chk("reset_oValid", oValid, 0);
            chk("reset_satCnt", satCnt, 0);
        end else begin
            tsat = 1'b0;
            xfer = oValid && oReady;
            chk("iReady_occupancy", iReady, !(sb.size() >= 2 && !oReady));
            chk("satCnt", satCnt, m_cnt);
            if (xfer) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    tsat = e[16];
                    chk("oData", oData, e[15:0]);
                    chk("oSat", oSat, e[16]);
                end
            end
            if (iClr) m_cnt = 0;
            else if (xfer && tsat && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (iValid && iReady) sb.push_back(ref_q(longint'(iData)));
        end
    end

    task automatic send(input logic [35:0] d);
        bit ok;
        ok = 1'b0;
        iValid = 1'b1;
        iData  = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (iReady) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        iValid = 1'b0;
        iData  = gen();
    endtask

    task automatic dir_chk(input logic [35:0] d, input logic [15:0] ed, input logic es);
        int n;
        n = 0;
        send(d);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n++;
            if (oValid) break;
        end
        chk("latency", n, 2);
        chk("dir_oData", oData, ed);
        chk("dir_oSat", oSat, es);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("iReady_after_reset", iReady, 1);
        @(posedge clk); #1;

        dir_chk(36'h0_4000_0000, 16'h8000, 1'b0);
        dir_chk(36'h0_0000_3FFF, 16'h0000, 1'b0);
        dir_chk(36'h0_0000_C000, 16'h0002, 1'b0);
`ifdef MAC_REQUANT_RNE_EN
        dir_chk(36'h0_0000_4000, 16'h0000, 1'b0);
`else
        dir_chk(36'h0_0000_4000, 16'h0001, 1'b0);
`endif
        dir_chk(36'h0_8000_0000, 16'hFFFF, 1'b1);
        idle(1);
        chk("satCnt_after_sat", satCnt, 1);

        // Backpressure: four words, oReady low for four cycles.
        fork
            begin
                for (int k = 1; k <= 4; k++) send(36'(k * 32'h8000));
            end
            begin
                idle(1);
                oReady = 1'b0;
                idle(4);
                oReady = 1'b1;
            end
        join
        idle(4);

        // Sticky counter: five saturated words into a 2-bit counter.
        iClr = 1'b1; idle(1); iClr = 1'b0;
        for (int k = 0; k < 5; k++) send(36'h0_8000_0000 + 36'(k));
        idle(4);
        chk("satCnt_sticky", satCnt, 3);

        // Async reset with both stages full.
        oReady = 1'b0;
        send(36'hF_FFFF_FFFF);
        send(36'h0_9000_0000);
        #2 rst_n = 1'b0;
        #1;
        chk("async_oValid", oValid, 0);
        chk("async_satCnt", satCnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        oReady = 1'b1;
        @(negedge clk);
        chk("iReady_after_midreset", iReady, 1);
        @(posedge clk); #1;
        dir_chk(36'h0_4000_0000, 16'h8000, 1'b0);

        // Clear in the same cycle as a saturated transfer.
        send(36'h0_8000_0000);
        @(posedge clk); #1;
        iClr = 1'b1;
        @(posedge clk); #1;
        iClr = 1'b0;
        @(negedge clk);
        chk("clear_race", satCnt, 0);
        @(posedge clk); #1;

        for (int c = 0; c < 800; c++) begin
            iValid = ($urandom % 4) != 0;
            iData  = gen();
            oReady = ($urandom % 3) != 0;
            iClr   = ($urandom % 40) == 0;
            @(posedge clk); #1;
        end
        iValid = 1'b0;
        iClr   = 1'b0;
        oReady = 1'b1;
        for (int k = 0; k < 50 && sb.size() != 0; k++) idle(1);
        chk("drain_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
